// File: rtl/conv_pe_mc.sv
// conv_pe_mc -- multi-channel convolution processing element.
//
// Holds a channel-major weight bank (G_NUM_CH x G_KERNEL_SIZE_MAX taps) and,
// for every output, accumulates ksize * G_NUM_CH fixed-point MACs from the
// ifmap stream. It then adds one upstream psum and emits a rescaled psum.
// Every accepted ifmap word is forwarded, registered, to the neighbour PE.
//
// Build option: define PE_SATURATE_EN to clamp psum_o to the DATA_W range;
// otherwise psum_o is the two's-complement wrap of the shifted accumulator.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   cfg_ksize_i                       taps per channel (0 or >KMAX -> KMAX)
//   weight_vld_i/weight_rdy_o/weight_i  weight write port (IDLE only)
//   weight_clr_i                      clears bank and write pointer, any state
//   ifmap_vld_i/ifmap_rdy_o/ifmap_i   activation stream (IDLE and MAC)
//   ifmap_fwd_vld_o/ifmap_fwd_o       registered copy of each accepted word
//   psum_vld_i/psum_rdy_o/psum_i      upstream partial sum (ACUM)
//   psum_vld_o/psum_rdy_i/psum_o      downstream result (OUT)
module conv_pe_mc #(
  parameter int G_TOP_BITS        = 2,
  parameter int G_BOT_BITS        = 14,
  parameter int G_KERNEL_SIZE_MAX = 5,
  parameter int G_NUM_CH          = 4,
  localparam int DATA_W = G_TOP_BITS + G_BOT_BITS,
  localparam int KS_W   = $clog2(G_KERNEL_SIZE_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [KS_W-1:0]   cfg_ksize_i,
  input  logic              weight_vld_i,
  output logic              weight_rdy_o,
  input  logic [DATA_W-1:0] weight_i,
  input  logic              weight_clr_i,
  input  logic              ifmap_vld_i,
  output logic              ifmap_rdy_o,
  input  logic [DATA_W-1:0] ifmap_i,
  output logic              ifmap_fwd_vld_o,
  output logic [DATA_W-1:0] ifmap_fwd_o,
  input  logic              psum_vld_i,
  output logic              psum_rdy_o,
  input  logic [DATA_W-1:0] psum_i,
  output logic              psum_vld_o,
  input  logic              psum_rdy_i,
  output logic [DATA_W-1:0] psum_o
);

  localparam int N_W    = G_NUM_CH * G_KERNEL_SIZE_MAX;
  localparam int WA_W   = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int CH_W   = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(N_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACUM, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [KS_W-1:0]           k_q, k_d, ksize_q, ksize_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [WA_W-1:0]           wptr_q, wptr_d;
  logic signed [DATA_W-1:0]  bank_q [N_W];
  logic signed [DATA_W-1:0]  bank_d [N_W];
  logic                      fwd_vld_q, fwd_vld_d;
  logic [DATA_W-1:0]         fwd_q, fwd_d;
  logic [DATA_W-1:0]         psum_q, psum_d;
  logic                      psum_vld_q, psum_vld_d;

  // Handshake readies are forced low while reset is held.
  assign weight_rdy_o = rst_ni & (state_q == S_IDLE);
  assign ifmap_rdy_o  = rst_ni & ((state_q == S_IDLE) | (state_q == S_MAC));
  assign psum_rdy_o   = rst_ni & (state_q == S_ACUM);

  assign ifmap_fwd_vld_o = fwd_vld_q;
  assign ifmap_fwd_o     = fwd_q;
  assign psum_vld_o      = psum_vld_q;
  assign psum_o          = psum_q;

  // In IDLE the accepted word is always tap (ch=0, k=0) with the freshly
  // sampled kernel size; in MAC the stored counters are used.
  logic              in_idle;
  logic [KS_W-1:0]   ksize_cfg, cur_ksize, cur_k, k_inc;
  logic [CH_W-1:0]   cur_ch;
  logic [WA_W-1:0]   widx;
  logic signed [DATA_W-1:0] x_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, psum_ext, acum_sum;
  logic              last_tap, k_wrap, ifmap_acc;
  logic [DATA_W-1:0] psum_res;

  assign in_idle   = (state_q == S_IDLE);
  assign ksize_cfg = ((cfg_ksize_i == '0) || (cfg_ksize_i > KS_W'(G_KERNEL_SIZE_MAX)))
                   ? KS_W'(G_KERNEL_SIZE_MAX) : cfg_ksize_i;
  assign cur_ksize = in_idle ? ksize_cfg : ksize_q;
  assign cur_k     = in_idle ? '0 : k_q;
  assign cur_ch    = in_idle ? '0 : ch_q;
  assign k_inc     = cur_k + KS_W'(1);
  assign k_wrap    = (k_inc == cur_ksize);
  assign last_tap  = (cur_ch == CH_W'(G_NUM_CH - 1)) && (cur_k == cur_ksize - KS_W'(1));
  assign widx      = WA_W'(cur_ch) * WA_W'(G_KERNEL_SIZE_MAX) + WA_W'(cur_k);
  assign x_s       = ifmap_i;
  assign prod      = x_s * bank_q[widx];
  assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // Upstream psum is aligned to the product's 2*G_BOT_BITS fractional bits.
  assign psum_ext  = {{(ACC_W-DATA_W-G_BOT_BITS){psum_i[DATA_W-1]}}, psum_i, {G_BOT_BITS{1'b0}}};
  assign acum_sum  = acc_q + psum_ext;
  assign ifmap_acc = ifmap_vld_i & ifmap_rdy_o;

`ifdef PE_SATURATE_EN
  logic signed [ACC_W-1:0]  acc_sh;
  logic [ACC_W-DATA_W:0]    acc_hi;
  assign acc_sh = acum_sum >>> G_BOT_BITS;
  // Value fits when every bit above the result's sign bit equals it.
  assign acc_hi = acc_sh[ACC_W-1:DATA_W-1];
  always_comb begin
    psum_res = acc_sh[DATA_W-1:0];
    if (!((&acc_hi) || !(|acc_hi))) begin
      psum_res = acc_sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign psum_res = acum_sum[G_BOT_BITS +: DATA_W];
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_d        = k_q;
    ch_d       = ch_q;
    ksize_d    = ksize_q;
    psum_d     = psum_q;
    psum_vld_d = psum_vld_q;
    fwd_vld_d  = 1'b0;
    fwd_d      = fwd_q;

    if (ifmap_acc) begin
      fwd_vld_d = 1'b1;
      fwd_d     = ifmap_i;
    end

    case (state_q)
      S_IDLE, S_MAC: begin
        if (ifmap_acc) begin
          acc_d = (in_idle ? '0 : acc_q) + prod_ext;
          if (in_idle) ksize_d = ksize_cfg;
          if (last_tap) begin
            state_d = S_ACUM;
            k_d     = '0;
            ch_d    = '0;
          end else begin
            state_d = S_MAC;
            if (k_wrap) begin
              k_d  = '0;
              ch_d = cur_ch + CH_W'(1);
            end else begin
              k_d  = k_inc;
              ch_d = cur_ch;
            end
          end
        end
      end
      S_ACUM: begin
        if (psum_vld_i) begin
          acc_d      = acum_sum;
          psum_d     = psum_res;
          psum_vld_d = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (psum_rdy_i) begin
          acc_d      = '0;
          psum_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Weight bank: clear beats a simultaneous write.
  always_comb begin
    bank_d = bank_q;
    wptr_d = wptr_q;
    if (weight_clr_i) begin
      for (int i = 0; i < N_W; i++) bank_d[i] = '0;
      wptr_d = '0;
    end else if (weight_vld_i && weight_rdy_o) begin
      bank_d[wptr_q] = weight_i;
      wptr_d = (wptr_q == WA_W'(N_W - 1)) ? '0 : wptr_q + WA_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      ch_q       <= '0;
      ksize_q    <= '0;
      wptr_q     <= '0;
      for (int i = 0; i < N_W; i++) bank_q[i] <= '0;
      fwd_vld_q  <= 1'b0;
      fwd_q      <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      ch_q       <= ch_d;
      ksize_q    <= ksize_d;
      wptr_q     <= wptr_d;
      bank_q     <= bank_d;
      fwd_vld_q  <= fwd_vld_d;
      fwd_q      <= fwd_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
    end
  end

endmodule

// File: tb/tb_conv_pe_mc.sv
// Directed bench for conv_pe_mc. Main instance has 2 channels x 5 taps
// (10 weight slots); a second 1-channel instance shares the inputs and is
// inspected only in the ksize=1 / single-channel case.
module tb_conv_pe_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cfg;
  logic        wvld, wclr, ivld, pvld, prdy;
  logic [15:0] wd, ifm, psum_in;
  logic        wrdy, irdy, fvld, prdy_o, pvld_o;
  logic [15:0] fwd, pout;
  logic        wrdy_1, irdy_1, fvld_1, prdy_o_1, pvld_o_1;
  logic [15:0] fwd_1, pout_1;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  conv_pe_mc #(.G_NUM_CH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_ksize_i(cfg),
    .weight_vld_i(wvld), .weight_rdy_o(wrdy), .weight_i(wd), .weight_clr_i(wclr),
    .ifmap_vld_i(ivld), .ifmap_rdy_o(irdy), .ifmap_i(ifm),
    .ifmap_fwd_vld_o(fvld), .ifmap_fwd_o(fwd),
    .psum_vld_i(pvld), .psum_rdy_o(prdy_o), .psum_i(psum_in),
    .psum_vld_o(pvld_o), .psum_rdy_i(prdy), .psum_o(pout));

  conv_pe_mc #(.G_NUM_CH(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_ksize_i(cfg),
    .weight_vld_i(wvld), .weight_rdy_o(wrdy_1), .weight_i(wd), .weight_clr_i(wclr),
    .ifmap_vld_i(ivld), .ifmap_rdy_o(irdy_1), .ifmap_i(ifm),
    .ifmap_fwd_vld_o(fvld_1), .ifmap_fwd_o(fwd_1),
    .psum_vld_i(pvld), .psum_rdy_o(prdy_o_1), .psum_i(psum_in),
    .psum_vld_o(pvld_o_1), .psum_rdy_i(prdy), .psum_o(pout_1));

  // Stimulus helpers: inputs change on the falling edge, DUT acts on the
  // rising edge, outputs are inspected on the following falling edge.
  task automatic wr(input logic [15:0] v);
    wvld = 1'b1; wd = v; @(negedge clk); wvld = 1'b0;
  endtask
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 10; i++) wr(v);
  endtask
  task automatic clear_w;
    wclr = 1'b1; @(negedge clk); wclr = 1'b0;
  endtask
  task automatic feed(input logic [15:0] x, input logic [2:0] ks);
    cfg = ks; ivld = 1'b1; ifm = x; @(negedge clk); ivld = 1'b0;
  endtask
  task automatic give_psum(input logic [15:0] p);
    pvld = 1'b1; psum_in = p; @(negedge clk); pvld = 1'b0;
    $display("psum in %h -> vld %0b out %h", p, pvld_o, pout);
  endtask
  task automatic release_out;
    prdy = 1'b1; @(negedge clk); prdy = 1'b0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    n_vec++; if (wrdy !== 1'b0) begin n_bad++; $display("FAIL reset_wrdy: got %b expected 0", wrdy); end
    n_vec++; if (irdy !== 1'b0) begin n_bad++; $display("FAIL reset_irdy: got %b expected 0", irdy); end
    n_vec++; if (prdy_o !== 1'b0) begin n_bad++; $display("FAIL reset_prdy: got %b expected 0", prdy_o); end
    n_vec++; if (pvld_o !== 1'b0 || pout !== 16'h0) begin n_bad++; $display("FAIL reset_psum: got vld %b out %h expected 0 0000", pvld_o, pout); end
    n_vec++; if (fvld !== 1'b0 || fwd !== 16'h0) begin n_bad++; $display("FAIL reset_fwd: got vld %b data %h expected 0 0000", fvld, fwd); end
    rst_n = 1'b1; @(negedge clk);
    n_vec++; if (wrdy !== 1'b1 || irdy !== 1'b1 || prdy_o !== 1'b0) begin n_bad++; $display("FAIL idle_rdy: got w%b i%b p%b expected w1 i1 p0", wrdy, irdy, prdy_o); end
  endtask

  task automatic test_basic_mac;
    fill(16'h2000);
    for (int i = 0; i < 6; i++) begin
      feed(16'h1000, 3'd3);
      n_vec++; if (fvld !== 1'b1 || fwd !== 16'h1000) begin n_bad++; $display("FAIL basic_fwd%0d: got vld %b data %h expected 1 1000", i, fvld, fwd); end
      if (i == 4) begin
        n_vec++; if (prdy_o !== 1'b0) begin n_bad++; $display("FAIL basic_early_acum: got %b expected 0", prdy_o); end
      end
    end
    n_vec++; if (prdy_o !== 1'b1 || pvld_o !== 1'b0) begin n_bad++; $display("FAIL basic_acum: got prdy %b pvld %b expected 1 0", prdy_o, pvld_o); end
    give_psum(16'h2000);
    n_vec++; if (pvld_o !== 1'b1 || pout !== 16'h5000) begin n_bad++; $display("FAIL basic_psum: got vld %b out %h expected 1 5000", pvld_o, pout); end
    n_vec++; if (fvld !== 1'b0) begin n_bad++; $display("FAIL basic_fwd_pulse: got %b expected 0", fvld); end
    release_out;
    n_vec++; if (pvld_o !== 1'b0 || wrdy !== 1'b1 || irdy !== 1'b1) begin n_bad++; $display("FAIL basic_release: got pvld %b w%b i%b expected 0 1 1", pvld_o, wrdy, irdy); end
  endtask

  task automatic test_saturate;
    logic [15:0] exp_v;
`ifdef PE_SATURATE_EN
    exp_v = 16'h7FFF;
`else
    exp_v = 16'hA000;
`endif
    fill(16'h6000);
    for (int i = 0; i < 10; i++) feed(16'h6000, 3'd5);
    give_psum(16'h0000);
    n_vec++; if (pvld_o !== 1'b1 || pout !== exp_v) begin n_bad++; $display("FAIL saturate: got vld %b out %h expected 1 %h", pvld_o, pout, exp_v); end
    release_out;
  endtask

  task automatic test_backpressure;
    feed(16'h1000, 3'd1);
    feed(16'h1000, 3'd1);
    give_psum(16'h0800);
    n_vec++; if (pvld_o !== 1'b1 || pout !== 16'h3800) begin n_bad++; $display("FAIL bp_psum: got vld %b out %h expected 1 3800", pvld_o, pout); end
    for (int i = 0; i < 3; i++) begin
      ivld = 1'b1; ifm = 16'h1234; @(negedge clk);
      n_vec++; if (pvld_o !== 1'b1 || pout !== 16'h3800) begin n_bad++; $display("FAIL bp_hold%0d: got vld %b out %h expected 1 3800", i, pvld_o, pout); end
      n_vec++; if (irdy !== 1'b0 || wrdy !== 1'b0 || fvld !== 1'b0) begin n_bad++; $display("FAIL bp_rdy%0d: got i%b w%b fwd%b expected 0 0 0", i, irdy, wrdy, fvld); end
    end
    ivld = 1'b0;
    release_out;
    n_vec++; if (pvld_o !== 1'b0 || irdy !== 1'b1) begin n_bad++; $display("FAIL bp_release: got pvld %b irdy %b expected 0 1", pvld_o, irdy); end
  endtask

  task automatic test_ksize_clamp;
    logic [2:0] ks_list [2];
    ks_list[0] = 3'd0; ks_list[1] = 3'd7;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 10; i++) begin
        feed(16'h0400, ks_list[t]);
        if (i == 8) begin
          n_vec++; if (prdy_o !== 1'b0) begin n_bad++; $display("FAIL clamp%0d_9th: got prdy %b expected 0", ks_list[t], prdy_o); end
        end
      end
      n_vec++; if (prdy_o !== 1'b1) begin n_bad++; $display("FAIL clamp%0d_10th: got prdy %b expected 1", ks_list[t], prdy_o); end
      give_psum(16'h0000);
      n_vec++; if (pout !== 16'h3C00) begin n_bad++; $display("FAIL clamp%0d_psum: got %h expected 3c00", ks_list[t], pout); end
      release_out;
    end
    do_reset;
    wr(16'h4000);
    feed(16'h2000, 3'd1);
    n_vec++; if (prdy_o_1 !== 1'b1 || prdy_o !== 1'b0) begin n_bad++; $display("FAIL k1_acum: got 1ch %b 2ch %b expected 1 0", prdy_o_1, prdy_o); end
    feed(16'h2000, 3'd1);
    n_vec++; if (prdy_o !== 1'b1) begin n_bad++; $display("FAIL k1_2ch_acum: got %b expected 1", prdy_o); end
    give_psum(16'h1000);
    n_vec++; if (pvld_o_1 !== 1'b1 || pout_1 !== 16'h3000) begin n_bad++; $display("FAIL k1_1ch_psum: got vld %b out %h expected 1 3000", pvld_o_1, pout_1); end
    n_vec++; if (pvld_o !== 1'b1 || pout !== 16'h3000) begin n_bad++; $display("FAIL k1_2ch_psum: got vld %b out %h expected 1 3000", pvld_o, pout); end
    release_out;
  endtask

  task automatic test_weights;
    // Clear with a simultaneous write: the write must be dropped.
    wclr = 1'b1; wvld = 1'b1; wd = 16'h7FFF; @(negedge clk); wclr = 1'b0; wvld = 1'b0;
    wr(16'h4000);
    feed(16'h4000, 3'd2);
    wvld = 1'b1; wd = 16'h4000; @(negedge clk); wvld = 1'b0;
    n_vec++; if (wrdy !== 1'b0 || irdy !== 1'b1) begin n_bad++; $display("FAIL mac_wrdy: got w%b i%b expected 0 1", wrdy, irdy); end
    for (int i = 0; i < 3; i++) feed(16'h4000, 3'd2);
    n_vec++; if (prdy_o !== 1'b1) begin n_bad++; $display("FAIL wt_acum: got %b expected 1", prdy_o); end
    give_psum(16'h0000);
    n_vec++; if (pout !== 16'h4000) begin n_bad++; $display("FAIL clr_and_ignore: got %h expected 4000", pout); end
    release_out;
    // Ten writes fill the bank; the eleventh wraps to slot 0.
    clear_w;
    fill(16'h2000);
    wr(16'h4000);
    feed(16'h4000, 3'd1);
    feed(16'h4000, 3'd1);
    give_psum(16'h0000);
    n_vec++; if (pout !== 16'h6000) begin n_bad++; $display("FAIL wptr_wrap: got %h expected 6000", pout); end
    release_out;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) feed(16'h2000, 3'd5);
    rst_n = 1'b0; #1;
    n_vec++; if (pvld_o !== 1'b0 || pout !== 16'h0) begin n_bad++; $display("FAIL midrst_psum: got vld %b out %h expected 0 0000", pvld_o, pout); end
    n_vec++; if (fvld !== 1'b0 || fwd !== 16'h0 || irdy !== 1'b0) begin n_bad++; $display("FAIL midrst_fwd: got fvld %b fwd %h irdy %b expected 0 0000 0", fvld, fwd, irdy); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    n_vec++; if (pvld_o !== 1'b0 || prdy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got pvld %b prdy %b expected 0 0", pvld_o, prdy_o); end
    // Weights were lost: only the upstream psum comes through.
    feed(16'h4000, 3'd1);
    feed(16'h4000, 3'd1);
    give_psum(16'h1000);
    n_vec++; if (pout !== 16'h1000) begin n_bad++; $display("FAIL midrst_wlost: got %h expected 1000", pout); end
    release_out;
    fill(16'h2000);
    for (int i = 0; i < 6; i++) feed(16'h1000, 3'd3);
    give_psum(16'h2000);
    n_vec++; if (pvld_o !== 1'b1 || pout !== 16'h5000) begin n_bad++; $display("FAIL midrst_rerun: got vld %b out %h expected 1 5000", pvld_o, pout); end
    release_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg = 3'd0; wvld = 1'b0; wclr = 1'b0; ivld = 1'b0;
    pvld = 1'b0; prdy = 1'b0; wd = '0; ifm = '0; psum_in = '0;
    test_reset;
    test_basic_mac;
    test_saturate;
    test_backpressure;
    test_ksize_clamp;
    test_weights;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
